// File: rtl/writeback_arb_stage.sv
// ---------------------------------------------------------------------------
// writeback_arb_stage
//
// Purpose:
//   Collects results from chan_p completion channels (ch0 = ALU/branch path,
//   ch1.. = load/mul/div), picks one channel per cycle to write the register
//   file, and registers the write (rd/data/enable) together with the ch0
//   branch/jump resolution for the fetch redirect logic.
//
// Parameters:
//   chan_p   number of completion channels (1..8)
//   width_p  data / pc width in bits
//   reg_w_p  register address width
//   rr_p     1 = round-robin arbitration, 0 = fixed priority (lowest wins)
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   stall_v_i         freezes arbitration and all output registers
//   v_i / ready_o     per-channel valid / grant (one-hot or zero)
//   rd_i, rd_w_v_i    per-channel destination register and write flag
//   data_i            per-channel result; ch0 branch target for branches
//   pc_i, jmp_v_i,
//   br_v_i, btaken_i  ch0 control-flow information
//   rd_o, rd_data_o,
//   rd_w_v_o          registered register-file write
//   br_v_o, btaken_o,
//   btgt_o            registered branch/jump resolution
//
// Handshake: channel i transfers in a cycle where v_i[i] & ready_o[i].
// A channel keeps v_i[i] and its payload stable until it is granted.
// ready_o is combinational from v_i, the round-robin pointer, stall_v_i and
// rst_i, and at most one bit is set.
// ---------------------------------------------------------------------------
module writeback_arb_stage #(
    parameter int chan_p  = 2,
    parameter int width_p = 32,
    parameter int reg_w_p = 5,
    parameter int rr_p    = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_v_i,
    input  logic [chan_p-1:0]            v_i,
    output logic [chan_p-1:0]            ready_o,
    input  logic [chan_p*reg_w_p-1:0]    rd_i,
    input  logic [chan_p-1:0]            rd_w_v_i,
    input  logic [chan_p*width_p-1:0]    data_i,
    input  logic [width_p-1:0]           pc_i,
    input  logic                         jmp_v_i,
    input  logic                         br_v_i,
    input  logic                         btaken_i,
    output logic [reg_w_p-1:0]           rd_o,
    output logic [width_p-1:0]           rd_data_o,
    output logic                         rd_w_v_o,
    output logic                         br_v_o,
    output logic                         btaken_o,
    output logic [width_p-1:0]           btgt_o
);

    localparam int PTR_W = (chan_p > 1) ? $clog2(chan_p) : 1;

    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic               w_gnt_v;
    logic [chan_p-1:0]  w_grant;

    logic [reg_w_p-1:0] w_rd;
    logic               w_rd_w_v;
    logic [width_p-1:0] w_data;

    logic [reg_w_p-1:0] r_rd;
    logic [width_p-1:0] r_rd_data;
    logic               r_rd_w_v;
    logic               r_br_v;
    logic               r_btaken;
    logic [width_p-1:0] r_btgt;

    // Scan channels starting at the pointer (fixed priority scans from 0),
    // wrapping modulo chan_p; the first valid channel wins.
    always_comb begin
        w_grant   = '0;
        w_gnt_v   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        if (!rst_i && !stall_v_i) begin
            for (int k = 0; k < chan_p; k++) begin
                if (rr_p != 0 && chan_p > 1) begin
                    w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
                end else begin
                    w_sum = (PTR_W+1)'(k);
                end
                if (w_sum >= (PTR_W+1)'(chan_p)) begin
                    w_sum = w_sum - (PTR_W+1)'(chan_p);
                end
                w_idx = w_sum[PTR_W-1:0];
                if (v_i[w_idx] && !w_gnt_v) begin
                    w_gnt_v          = 1'b1;
                    w_gnt_idx        = w_idx;
                    w_grant[w_idx]   = 1'b1;
                end
            end
        end
    end

    assign ready_o = w_grant;

    // Payload mux driven by the one-hot grant.
    always_comb begin
        w_rd     = '0;
        w_rd_w_v = 1'b0;
        w_data   = '0;
        for (int i = 0; i < chan_p; i++) begin
            if (w_grant[i]) begin
                w_rd     = rd_i[i*reg_w_p +: reg_w_p];
                w_rd_w_v = rd_w_v_i[i];
                w_data   = data_i[i*width_p +: width_p];
            end
        end
    end

    // Round-robin pointer: moves just past the winner after each transfer.
    // Stall already suppresses the grant, so it needs no separate term.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (rr_p != 0 && chan_p > 1 && w_gnt_v) begin
            if (w_gnt_idx == PTR_W'(chan_p - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gnt_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd      <= '0;
            r_rd_data <= '0;
            r_rd_w_v  <= 1'b0;
            r_br_v    <= 1'b0;
            r_btaken  <= 1'b0;
            r_btgt    <= '0;
        end else if (!stall_v_i) begin
            if (w_gnt_v) begin
                r_rd <= w_rd;
                // Jumps write the link address instead of the target.
                if (w_grant[0] && jmp_v_i) begin
                    r_rd_data <= pc_i + width_p'(4);
                end else begin
                    r_rd_data <= w_data;
                end
                // x0 writes are dropped, but the transfer is still consumed.
                r_rd_w_v <= w_rd_w_v && (w_rd != '0);
                if (w_grant[0]) begin
                    r_br_v   <= br_v_i | jmp_v_i;
                    r_btaken <= btaken_i | jmp_v_i;
                    r_btgt   <= data_i[width_p-1:0];
                end else begin
                    r_br_v   <= 1'b0;
                end
            end else begin
                r_rd_w_v <= 1'b0;
                r_br_v   <= 1'b0;
            end
        end
    end

    assign rd_o      = r_rd;
    assign rd_data_o = r_rd_data;
    assign rd_w_v_o  = r_rd_w_v;
    assign br_v_o    = r_br_v;
    assign btaken_o  = r_btaken;
    assign btgt_o    = r_btgt;

endmodule

// File: tb/tb_writeback_arb_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_arb_stage
//
// Purpose:
//   Directed checks of writeback_arb_stage. Two 3-channel instances share all
//   inputs: u_rr uses round-robin arbitration, u_fp fixed priority.
// ---------------------------------------------------------------------------
module tb_writeback_arb_stage;

    localparam int CH = 3;
    localparam int W  = 32;
    localparam int RW = 5;

    logic           clk;
    logic           rst;
    logic           stall;
    logic [CH-1:0]  v;
    logic [CH*RW-1:0] rd;
    logic [CH-1:0]  wv;
    logic [CH*W-1:0] data;
    logic [W-1:0]   pc;
    logic           jmp;
    logic           br;
    logic           btaken;

    logic [CH-1:0]  rr_ready, fp_ready;
    logic [RW-1:0]  rr_rd, fp_rd;
    logic [W-1:0]   rr_data, fp_data;
    logic           rr_wv, fp_wv;
    logic           rr_brv, fp_brv;
    logic           rr_bt, fp_bt;
    logic [W-1:0]   rr_btgt, fp_btgt;

    int checks = 0;
    int errors = 0;

    writeback_arb_stage #(.chan_p(CH), .width_p(W), .reg_w_p(RW), .rr_p(1)) u_rr (
        .clk_i(clk), .rst_i(rst), .stall_v_i(stall), .v_i(v), .ready_o(rr_ready),
        .rd_i(rd), .rd_w_v_i(wv), .data_i(data), .pc_i(pc), .jmp_v_i(jmp),
        .br_v_i(br), .btaken_i(btaken), .rd_o(rr_rd), .rd_data_o(rr_data),
        .rd_w_v_o(rr_wv), .br_v_o(rr_brv), .btaken_o(rr_bt), .btgt_o(rr_btgt)
    );

    writeback_arb_stage #(.chan_p(CH), .width_p(W), .reg_w_p(RW), .rr_p(0)) u_fp (
        .clk_i(clk), .rst_i(rst), .stall_v_i(stall), .v_i(v), .ready_o(fp_ready),
        .rd_i(rd), .rd_w_v_i(wv), .data_i(data), .pc_i(pc), .jmp_v_i(jmp),
        .br_v_i(br), .btaken_i(btaken), .rd_o(fp_rd), .rd_data_o(fp_data),
        .rd_w_v_o(fp_wv), .br_v_o(fp_brv), .btaken_o(fp_bt), .btgt_o(fp_btgt)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [RW-1:0] r, input logic w,
                          input logic [W-1:0] d);
        rd[ch*RW +: RW] = r;
        wv[ch]          = w;
        data[ch*W +: W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; v = '0; stall = 1'b0; jmp = 1'b0; br = 1'b0; btaken = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; jmp = 1'b0; br = 1'b0; btaken = 1'b0; pc = '0;
        v = 3'b111;
        for (int i = 0; i < CH; i++) set_ch(i, RW'(i + 1), 1'b1, W'(32'h10 + i));
        step();
        step();
        checks++; if (rr_ready !== 3'b000 || fp_ready !== 3'b000) begin errors++;
            $display("FAIL reset_ready: got rr=%b fp=%b exp 000", rr_ready, fp_ready); end
        checks++; if (rr_rd !== 5'd0 || rr_data !== 32'd0 || rr_wv !== 1'b0) begin errors++;
            $display("FAIL reset_wr: got rd=%0d data=%h wv=%b exp 0", rr_rd, rr_data, rr_wv); end
        checks++; if (rr_brv !== 1'b0 || rr_bt !== 1'b0 || rr_btgt !== 32'd0) begin errors++;
            $display("FAIL reset_br: got brv=%b bt=%b tgt=%h exp 0", rr_brv, rr_bt, rr_btgt); end
        rst = 1'b0;
        #1;
        checks++; if (rr_ready !== 3'b001 || fp_ready !== 3'b001) begin errors++;
            $display("FAIL reset_release_grant: got rr=%b fp=%b exp 001", rr_ready, fp_ready); end
        step();
        v = '0;
        checks++; if (rr_rd !== 5'd1 || rr_data !== 32'h10 || rr_wv !== 1'b1) begin errors++;
            $display("FAIL reset_release_out: got rd=%0d data=%h wv=%b exp 1/10/1", rr_rd, rr_data, rr_wv); end
    endtask

    task automatic test_alu();
        do_reset();
        v = 3'b001; set_ch(0, 5'd5, 1'b1, 32'h1234);
        #1;
        checks++; if (rr_ready !== 3'b001) begin errors++;
            $display("FAIL alu_ready: got %b exp 001", rr_ready); end
        step();
        v = '0;
        checks++; if (rr_rd !== 5'd5 || rr_data !== 32'h1234 || rr_wv !== 1'b1 || rr_brv !== 1'b0) begin errors++;
            $display("FAIL alu_out: got rd=%0d data=%h wv=%b brv=%b exp 5/1234/1/0", rr_rd, rr_data, rr_wv, rr_brv); end
        step();
        checks++; if (rr_wv !== 1'b0 || rr_rd !== 5'd5 || rr_data !== 32'h1234) begin errors++;
            $display("FAIL alu_idle: got wv=%b rd=%0d data=%h exp 0/5/1234", rr_wv, rr_rd, rr_data); end
    endtask

    task automatic test_jal();
        do_reset();
        v = 3'b001; pc = 32'h100; jmp = 1'b1; set_ch(0, 5'd1, 1'b1, 32'h200);
        step();
        v = '0; jmp = 1'b0;
        checks++; if (rr_data !== 32'h104 || rr_rd !== 5'd1 || rr_wv !== 1'b1) begin errors++;
            $display("FAIL jal_link: got data=%h rd=%0d wv=%b exp 104/1/1", rr_data, rr_rd, rr_wv); end
        checks++; if (rr_brv !== 1'b1 || rr_bt !== 1'b1 || rr_btgt !== 32'h200) begin errors++;
            $display("FAIL jal_br: got brv=%b bt=%b tgt=%h exp 1/1/200", rr_brv, rr_bt, rr_btgt); end
        // Link address wraps at 2^32.
        v = 3'b001; pc = 32'hFFFF_FFFE; jmp = 1'b1; set_ch(0, 5'd2, 1'b1, 32'h40);
        step();
        v = '0; jmp = 1'b0;
        checks++; if (rr_data !== 32'h0000_0002) begin errors++;
            $display("FAIL jal_wrap: got %h exp 00000002", rr_data); end
        // Not-taken conditional branch writes no register.
        v = 3'b001; br = 1'b1; btaken = 1'b0; set_ch(0, 5'd0, 1'b0, 32'h300);
        step();
        v = '0; br = 1'b0;
        checks++; if (rr_brv !== 1'b1 || rr_bt !== 1'b0 || rr_btgt !== 32'h300 || rr_wv !== 1'b0) begin errors++;
            $display("FAIL br_nt: got brv=%b bt=%b tgt=%h wv=%b exp 1/0/300/0", rr_brv, rr_bt, rr_btgt, rr_wv); end
        // Taken branch, then a ch1 grant: br_v_o drops, target keeps.
        v = 3'b001; br = 1'b1; btaken = 1'b1; set_ch(0, 5'd0, 1'b0, 32'h500);
        step();
        br = 1'b0; btaken = 1'b0;
        v = 3'b010; set_ch(1, 5'd9, 1'b1, 32'h99);
        step();
        v = '0;
        checks++; if (rr_brv !== 1'b0 || rr_bt !== 1'b1 || rr_btgt !== 32'h500 || rr_rd !== 5'd9) begin errors++;
            $display("FAIL ch1_after_br: got brv=%b bt=%b tgt=%h rd=%0d exp 0/1/500/9", rr_brv, rr_bt, rr_btgt, rr_rd); end
    endtask

    task automatic test_round_robin();
        int exp_ch;
        do_reset();
        v = 3'b111;
        for (int i = 0; i < CH; i++) set_ch(i, RW'(10 + i), 1'b1, W'(32'hA0 + i));
        for (int k = 0; k < 6; k++) begin
            exp_ch = k % CH;
            #1;
            checks++; if (rr_ready !== CH'(1 << exp_ch)) begin errors++;
                $display("FAIL rr_grant_%0d: got %b exp ch%0d", k, rr_ready, exp_ch); end
            checks++; if (fp_ready !== 3'b001) begin errors++;
                $display("FAIL fp_grant_%0d: got %b exp 001", k, fp_ready); end
            step();
            checks++; if (rr_rd !== RW'(10 + exp_ch) || rr_data !== W'(32'hA0 + exp_ch)) begin errors++;
                $display("FAIL rr_out_%0d: got rd=%0d data=%h exp ch%0d", k, rr_rd, rr_data, exp_ch); end
        end
        v = '0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        v = 3'b110;
        set_ch(1, 5'd11, 1'b1, 32'hB1);
        set_ch(2, 5'd12, 1'b1, 32'hB2);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (fp_ready !== 3'b010) begin errors++;
                $display("FAIL fp_ch1_%0d: got %b exp 010", k, fp_ready); end
            step();
            checks++; if (fp_rd !== 5'd11 || fp_data !== 32'hB1) begin errors++;
                $display("FAIL fp_ch1_out_%0d: got rd=%0d data=%h exp 11/b1", k, fp_rd, fp_data); end
        end
        v = 3'b100;
        #1;
        checks++; if (fp_ready !== 3'b100) begin errors++;
            $display("FAIL fp_ch2: got %b exp 100", fp_ready); end
        step();
        v = '0;
        checks++; if (fp_rd !== 5'd12 || fp_data !== 32'hB2 || fp_wv !== 1'b1) begin errors++;
            $display("FAIL fp_ch2_out: got rd=%0d data=%h wv=%b exp 12/b2/1", fp_rd, fp_data, fp_wv); end
    endtask

    task automatic test_stall();
        do_reset();
        v = 3'b001; set_ch(0, 5'd7, 1'b1, 32'h77);
        step();
        v = 3'b010; set_ch(1, 5'd3, 1'b1, 32'h3333);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (rr_ready !== 3'b000) begin errors++;
                $display("FAIL stall_ready_%0d: got %b exp 000", k, rr_ready); end
            step();
            checks++; if (rr_rd !== 5'd7 || rr_data !== 32'h77 || rr_wv !== 1'b1) begin errors++;
                $display("FAIL stall_hold_%0d: got rd=%0d data=%h wv=%b exp 7/77/1", k, rr_rd, rr_data, rr_wv); end
        end
        stall = 1'b0;
        #1;
        checks++; if (rr_ready !== 3'b010) begin errors++;
            $display("FAIL stall_release: got %b exp 010", rr_ready); end
        step();
        checks++; if (rr_rd !== 5'd3 || rr_data !== 32'h3333 || rr_wv !== 1'b1) begin errors++;
            $display("FAIL stall_release_out: got rd=%0d data=%h wv=%b exp 3/3333/1", rr_rd, rr_data, rr_wv); end
        // x0 destination: transfer consumed, write suppressed.
        set_ch(1, 5'd0, 1'b1, 32'h55);
        #1;
        checks++; if (rr_ready !== 3'b010) begin errors++;
            $display("FAIL x0_ready: got %b exp 010", rr_ready); end
        step();
        v = '0;
        checks++; if (rr_wv !== 1'b0 || rr_data !== 32'h55 || rr_rd !== 5'd0) begin errors++;
            $display("FAIL x0_out: got wv=%b data=%h rd=%0d exp 0/55/0", rr_wv, rr_data, rr_rd); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; v = '0; rd = '0; wv = '0; data = '0;
        pc = '0; jmp = 1'b0; br = 1'b0; btaken = 1'b0;
        test_reset();
        test_alu();
        test_jal();
        test_round_robin();
        test_fixed_priority();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
